cr_tx_sched: RTL

- Transmit scheduler in front of the cwnd credit engine core.
- Collects flow IDs that become ready to transmit: up to two per cycle, from the core's tx_enq_fid1 and tx_enq_fid2 outputs.
- Holds them in a FIFO of ready flows and issues at most one flow ID per cycle on the core's tx_fid_in.
- Issue order is first-come round-robin, gated by a downstream ready and a pause control.

---
 rtl/cr_tx_sched_pkg.sv | 28 ++
 rtl/cr_tx_sched_fifo.sv | 92 +++++++++
 rtl/cr_tx_sched.sv | 110 +++++++++++
 3 files changed

// File: rtl/cr_tx_sched_pkg.sv
// ============================================================================
// Module      : cr_tx_sched_pkg
// Description : Shared issue-state encodings, stats width and global flow
//               defaults for the cr_tx_sched transmit scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef FLOW_ID_W
`define FLOW_ID_W 8
`endif
`ifndef MAX_FLOW_CNT
`define MAX_FLOW_CNT 16
`endif
`ifndef MAX_FLOW_CNT_WIDTH
`define MAX_FLOW_CNT_WIDTH 4
`endif
`ifndef FLOW_ID_NONE
`define FLOW_ID_NONE 0
`endif

package cr_tx_sched_pkg;
    localparam logic [0:0] SCHED_IDLE   = 1'b0;
    localparam logic [0:0] SCHED_ACTIVE = 1'b1;
    localparam int         STATS_W      = 32;
endpackage

`default_nettype wire

// File: rtl/cr_tx_sched_fifo.sv
// ============================================================================
// Module      : sched_fid_fifo_2w1r
// Description : Dual-write, single-read ready-flow FIFO with occupancy and
//               full handling (drops reported per cycle).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sched_fid_fifo_2w1r #(
    parameter int                FID_W    = 8,
    parameter int                ADDR_W   = 4,
    parameter int                DEPTH    = 16,
    parameter logic [FID_W-1:0]  FID_NONE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [FID_W-1:0]  fid0,
    input  logic [FID_W-1:0]  fid1,
    input  logic              pop,
    output logic [FID_W-1:0]  rd_data,
    output logic [ADDR_W:0]   occupancy,
    output logic [ADDR_W:0]   occupancy_next,
    output logic [1:0]        drops
);
    localparam logic [ADDR_W+1:0] DEPTH_EXT = (ADDR_W+2)'(DEPTH);

    logic [FID_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              valid0;
    logic              valid1;
    logic              acc0;
    logic              acc1;
    logic [ADDR_W+1:0] free_space;
    logic [FID_W-1:0]  first_fid;
    logic              first_en;

    assign valid0     = (fid0 != FID_NONE);
    assign valid1     = (fid1 != FID_NONE);
    // Pop in the same cycle frees one slot for this cycle's pushes.
    assign free_space = DEPTH_EXT - {1'b0, occupancy} + (ADDR_W+2)'(pop);

    always_comb begin
        acc0      = 1'b0;
        acc1      = 1'b0;
        first_fid = fid0;
        first_en  = 1'b0;
        drops     = 2'd0;
        if (!flush) begin
            acc0  = valid0 && (free_space != '0);
            acc1  = valid1 && (valid0 ? (free_space >= (ADDR_W+2)'(2)) : (free_space != '0));
            drops = 2'((valid0 && !acc0)) + 2'((valid1 && !acc1));
        end
        if (acc0) begin
            first_fid = fid0;
            first_en  = 1'b1;
        end else if (acc1) begin
            first_fid = fid1;
            first_en  = 1'b1;
        end
    end

    always_comb begin
        occupancy_next = '0;
        if (!flush)
            occupancy_next = occupancy + (ADDR_W+1)'(acc0) + (ADDR_W+1)'(acc1) - (ADDR_W+1)'(pop);
    end

    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (first_en)
            mem[wr_ptr] <= first_fid;
        if (acc0 && acc1)
            mem[wr_ptr + ADDR_W'(1)] <= fid1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            wr_ptr    <= wr_ptr + ADDR_W'(acc0) + ADDR_W'(acc1);
            rd_ptr    <= rd_ptr + ADDR_W'(pop);
            occupancy <= occupancy_next;
        end
    end
endmodule

`default_nettype wire

// File: rtl/cr_tx_sched.sv
// ============================================================================
// Module      : cr_tx_sched
// Description : Transmit scheduler: queues up to two ready flows per cycle and
//               issues one per cycle, gated by tx_ready/pause, with flush.
//               Optional counters enabled by macro CR_SCHED_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cr_tx_sched
    import cr_tx_sched_pkg::*;
#(
    parameter int                FID_W    = `FLOW_ID_W,
    parameter int                DEPTH    = `MAX_FLOW_CNT,
    parameter int                ADDR_W   = `MAX_FLOW_CNT_WIDTH,
    parameter logic [FID_W-1:0]  FID_NONE = FID_W'(`FLOW_ID_NONE)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [FID_W-1:0]    enq_fid0_in,
    input  logic [FID_W-1:0]    enq_fid1_in,
    input  logic                tx_ready_in,
    input  logic                pause_in,
    input  logic                flush_in,
    output logic [FID_W-1:0]    tx_fid_out,
    output logic [ADDR_W:0]     occupancy_out,
    output logic                empty_out,
`ifdef CR_SCHED_STATS_EN
    output logic [STATS_W-1:0]  stat_issued_out,
    output logic [STATS_W-1:0]  stat_dropped_out,
`endif
    output logic                overflow_err_out
);
    logic [FID_W-1:0] rd_data;
    logic [ADDR_W:0]  occupancy_next;
    logic [1:0]       drops;
    logic             pop;
    logic [0:0]       state;
    logic [0:0]       state_next;
    logic [FID_W-1:0] tx_fid_q;
    logic             overflow_q;

    // Registered occupancy only: a freshly pushed entry waits one cycle.
    assign pop = tx_ready_in && !pause_in && !flush_in && (occupancy_out != '0);

    sched_fid_fifo_2w1r #(
        .FID_W    (FID_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .FID_NONE (FID_NONE)
    ) u_fifo (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush_in),
        .fid0           (enq_fid0_in),
        .fid1           (enq_fid1_in),
        .pop            (pop),
        .rd_data        (rd_data),
        .occupancy      (occupancy_out),
        .occupancy_next (occupancy_next),
        .drops          (drops)
    );

    always_comb begin
        state_next = state;
        if (flush_in)
            state_next = SCHED_IDLE;
        else if (state == SCHED_IDLE)
            state_next = (occupancy_next != '0) ? SCHED_ACTIVE : SCHED_IDLE;
        else
            state_next = (occupancy_next == '0) ? SCHED_IDLE : SCHED_ACTIVE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= SCHED_IDLE;
            tx_fid_q   <= FID_NONE;
            overflow_q <= 1'b0;
        end else begin
            state    <= state_next;
            tx_fid_q <= pop ? rd_data : FID_NONE;
            if (drops != 2'd0)
                overflow_q <= 1'b1;
        end
    end

    assign tx_fid_out       = tx_fid_q;
    assign empty_out        = (state == SCHED_IDLE);
    assign overflow_err_out = overflow_q;

`ifdef CR_SCHED_STATS_EN
    logic [STATS_W-1:0] issued_q;
    logic [STATS_W-1:0] dropped_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issued_q  <= '0;
            dropped_q <= '0;
        end else begin
            issued_q  <= issued_q + STATS_W'(pop);
            dropped_q <= dropped_q + STATS_W'(drops);
        end
    end

    assign stat_issued_out  = issued_q;
    assign stat_dropped_out = dropped_q;
`endif
endmodule

`default_nettype wire
